// File: rtl/fpu_fclass_stage.sv
// Two-stage FCLASS pipeline: stage 0 holds the operand for the external classifier,
// stage 1 registers the zero-extended class vector for integer writeback.
// Optional macro ONEHOT_CHECK_EN adds a sticky one-hot check on the class vector.
module fpu_fclass_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_operand,
    input  logic [TAG_W-1:0]  in_rd,
    output logic [DATA_W-1:0] cls_operand,
    input  logic [9:0]        cls_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_rd,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              cls_err
);

    localparam int unsigned CLS_W = 10;

    logic             s0_valid;
    logic [TAG_W-1:0] s0_rd;
    logic             s0_adv_c;
    logic             accept_c;
    logic             retire_c;

    // Stage 0 drains when stage 1 is empty or is handing its result off this cycle.
    assign s0_adv_c = s0_valid & (~out_valid | out_ready);
    assign in_ready = ~s0_valid | s0_adv_c;
    assign accept_c = in_valid & in_ready;
    // A result killed by flush does not count as retired.
    assign retire_c = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s0_valid    <= 1'b0;
            cls_operand <= '0;
            s0_rd       <= '0;
        end else if (flush) begin
            s0_valid <= 1'b0;
        end else if (accept_c) begin
            s0_valid    <= 1'b1;
            cls_operand <= in_operand;
            s0_rd       <= in_rd;
        end else if (s0_adv_c) begin
            s0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s0_adv_c) begin
            out_valid  <= 1'b1;
            out_result <= XLEN'(cls_result);
            out_rd     <= s0_rd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            retired_cnt <= '0;
        end else if (retire_c) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic onehot_c;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign onehot_c = (cls_result != '0) &&
                      ((cls_result & (cls_result - CLS_W'(1))) == '0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cls_err <= 1'b0;
        end else if (s0_adv_c && !onehot_c) begin
            cls_err <= 1'b1;
        end
    end
`else
    assign cls_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_fclass_stage.sv
// Bench for fpu_fclass_stage: bf16 behavioural classifier, queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_fpu_fclass_stage;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_operand = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] cls_operand;
    logic [9:0]  cls_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [15:0] retired_cnt;
    logic        cls_err;
    logic        force_cls = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_fclass_stage dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_rd(in_rd),
        .cls_operand(cls_operand), .cls_result(cls_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .retired_cnt(retired_cnt), .cls_err(cls_err)
    );

    always #5 clk = ~clk;

    // bfloat16 classification; bit index follows {qnan,snan,+inf,+norm,+sub,+0,-0,-sub,-norm,-inf}.
    function automatic logic [9:0] classify(input logic [15:0] x);
        int e, m, idx;
        bit neg;
        neg = x[15];
        e = (int'(x) >> 7) & 255;
        m = int'(x) & 127;
        if (e == 255) begin
            if (m == 0) idx = neg ? 0 : 7;
            else idx = (m >= 64) ? 9 : 8;
        end else if (e == 0) begin
            if (m == 0) idx = neg ? 3 : 4;
            else idx = neg ? 2 : 5;
        end else begin
            idx = neg ? 1 : 6;
        end
        return 10'(1 << idx);
    endfunction

    always_comb cls_result = force_cls ? 10'h003 : classify(cls_operand);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ops in flight, oldest first; 'vis' marks the one presented at the output.
    typedef struct {
        logic [15:0] op;
        logic [4:0]  rd;
        bit          vis;
        logic [9:0]  res;
    } ent_t;

    ent_t        q[$];
    int          m_cnt = 0;
    bit          m_err = 0;
    logic [31:0] got[$];
    logic [4:0]  got_rd[$];

    function automatic bit m_has_s0();
        return (q.size() > 0) && !q[q.size()-1].vis;
    endfunction

    function automatic bit m_ready();
        bit adv;
        adv = m_has_s0() && (q.size() == 1 || out_ready);
        return !m_has_s0() || adv;
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q.delete();
            m_cnt = 0;
            m_err = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            bit acc;
            acc = in_valid && m_ready();
            if (q.size() > 0 && q[0].vis && out_ready) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (q.size() > 0 && !q[0].vis) begin
                q[0].vis = 1;
                q[0].res = force_cls ? 10'h003 : classify(q[0].op);
`ifdef ONEHOT_CHECK_EN
                if ($countones(q[0].res) != 1) m_err = 1;
`endif
            end
            if (acc) q.push_back('{op: in_operand, rd: in_rd, vis: 0, res: '0});
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        ev = (q.size() > 0) && q[0].vis;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        chk("cls_err", 32'(cls_err), 32'(m_err));
        if (ev) begin
            chk("out_result", out_result, 32'(q[0].res));
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        end
        if (m_has_s0()) chk("cls_operand", 32'(cls_operand), 32'(q[q.size()-1].op));
        if (out_valid && out_ready && rst_l && !flush) begin
            got.push_back(out_result);
            got_rd.push_back(out_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] op, input logic [4:0] rd);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_operand = op;
        in_rd = rd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [31:0] exp);
        chk(nm, (got.size() > idx) ? got[idx] : 32'hDEAD_BEEF, exp);
    endtask

    initial begin
        rst_l = 1'b0;
        #2;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_result", out_result, 32'(0));
        chk("rst_out_rd", 32'(out_rd), 32'(0));
        chk("rst_cls_operand", 32'(cls_operand), 32'(0));
        chk("rst_retired", 32'(retired_cnt), 32'(0));
        chk("rst_cls_err", 32'(cls_err), 32'(0));
        #21 rst_l = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Single op: 1.0 in bf16 is +normal
        send(16'h3F80, 5'd3);
        tick();
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_result", out_result, 32'h0000_0040);
        chk("single_rd", 32'(out_rd), 32'(3));
        tick();
        chk("single_retired", 32'(retired_cnt), 32'(1));

        // Back-to-back stream with writeback always ready
        got.delete(); got_rd.delete();
        send(16'h7F80, 5'd1);
        send(16'h8000, 5'd2);
        send(16'h7FC1, 5'd3);
        send(16'hFF80, 5'd4);
        repeat (3) tick();
        chk("b2b_count", 32'(got.size()), 32'(4));
        chk_got("b2b_0", 0, 32'h080);
        chk_got("b2b_1", 1, 32'h008);
        chk_got("b2b_2", 2, 32'h200);
        chk_got("b2b_3", 3, 32'h001);
        chk("b2b_retired", 32'(retired_cnt), 32'(5));

        // Back-pressure: writeback stalls for 5 cycles during a 4-op stream
        got.delete(); got_rd.delete();
        fork
            begin
                send(16'h3F80, 5'd10);
                send(16'h0001, 5'd11);
                send(16'hBF80, 5'd12);
                send(16'h807F, 5'd13);
            end
            begin
                out_ready = 1'b0;
                repeat (3) tick();
                chk("bp_in_ready_low", 32'(in_ready), 32'(0));
                chk("bp_hold_result", out_result, 32'h040);
                tick();
                chk("bp_hold_stable", out_result, 32'h040);
                chk("bp_hold_rd", 32'(out_rd), 32'(10));
                tick();
                out_ready = 1'b1;
            end
        join
        repeat (3) tick();
        chk("bp_count", 32'(got.size()), 32'(4));
        chk_got("bp_0", 0, 32'h040);
        chk_got("bp_1", 1, 32'h020);
        chk_got("bp_2", 2, 32'h002);
        chk_got("bp_3", 3, 32'h004);
        chk("bp_rd_last", (got_rd.size() > 3) ? 32'(got_rd[3]) : 32'hFFFF, 32'(13));
        chk("bp_retired", 32'(retired_cnt), 32'(9));

        // Flush with both stages occupied
        out_ready = 1'b0;
        send(16'h3F80, 5'd20);
        send(16'h7F80, 5'd21);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        chk("flush_retired", 32'(retired_cnt), 32'(9));
        got.delete(); got_rd.delete();
        out_ready = 1'b1;
        send(16'h0001, 5'd7);
        repeat (2) tick();
        chk_got("flush_next", 0, 32'h020);
        chk("flush_next_retired", 32'(retired_cnt), 32'(10));

        // Asynchronous reset between edges while stalled
        out_ready = 1'b0;
        send(16'hFF80, 5'd5);
        send(16'h8000, 5'd6);
        #3 rst_l = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_out_result", out_result, 32'(0));
        chk("arst_retired", 32'(retired_cnt), 32'(0));
        chk("arst_cls_operand", 32'(cls_operand), 32'(0));
        #10 rst_l = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Non one-hot classifier vector
        force_cls = 1'b1;
        send(16'h3F80, 5'd9);
        tick();
        force_cls = 1'b0;
        chk("oh_result", out_result, 32'h003);
`ifdef ONEHOT_CHECK_EN
        chk("oh_err_set", 32'(cls_err), 32'(1));
        repeat (2) tick();
        chk("oh_err_sticky", 32'(cls_err), 32'(1));
`else
        chk("oh_err_tied", 32'(cls_err), 32'(0));
        repeat (2) tick();
        chk("oh_err_tied_later", 32'(cls_err), 32'(0));
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
